// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin owner of a shared 4-input mux: registered one-hot gnt, sel and busy
// Optional hold timeout with a one-cycle preemption gap: RR_ARB_TIMEOUT_EN
module rr_mux_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            busy
);

    if (NREQ != 4 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_param_check
        $error("rr_mux_arbiter: unsupported NREQ or HOLD_MAX");
    end

`ifdef RR_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, PREEMPT = 2'd2} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_cnt, cnt_d;
    logic [3:0] owner_hot;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

    state_t     state, state_d;
    logic [3:0] gnt_d;
    logic [1:0] sel_d;
    logic [1:0] last, last_d;
    logic [2:0] pick;
    logic       issue;

    // Searches base+1, base+2, base+3, base; returns {found, index}
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!res[2] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        sel_d   = sel;
        last_d  = last;
        pick    = 3'b000;
        issue   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d     = hold_cnt;
        owner_hot = 4'b0001 << sel;
`endif
        case (state)
            IDLE: begin
                pick  = rr_pick(req, last);
                issue = pick[2];
            end
            GRANT: begin
                if (!req[sel]) begin
                    // Releasing owner is searched last and its req is low, so it cannot win
                    pick  = rr_pick(req, sel);
                    issue = pick[2];
                    if (!pick[2]) begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST && |(req & ~owner_hot)) begin
                    gnt_d   = '0;
                    state_d = PREEMPT;
                end else if (hold_cnt != HOLD_LAST) begin
                    cnt_d = hold_cnt + 8'd1;
                end
`endif
            end
`ifdef RR_ARB_TIMEOUT_EN
            PREEMPT: begin
                // Former owner is excluded once; it competes again only if nobody else wants the mux
                pick = rr_pick(req & ~owner_hot, last);
                if (!pick[2]) begin
                    pick = rr_pick(req, last);
                end
                issue = pick[2];
                if (!pick[2]) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (issue) begin
            gnt_d   = 4'b0001 << pick[1:0];
            sel_d   = pick[1:0];
            last_d  = pick[1:0];
            state_d = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= 2'd0;
            busy  <= 1'b0;
            last  <= 2'd3;
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            sel   <= sel_d;
            busy  <= |gnt_d;
            last  <= last_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt <= 8'd0;
        end else begin
            hold_cnt <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed bench for rr_mux_arbiter, checks {gnt, sel, busy}
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.NREQ(4), .HOLD_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic eb);
        logic [6:0] obs, exp;
        obs = {gnt, sel, busy};
        exp = {eg, es, eb};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got gnt/sel/busy=%b/%0d/%b want %b/%0d/%b",
                   tag, obs[6:3], obs[2:1], obs[0], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        logic [1:0] o;
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // reset state
        reset_n = 1'b0;
        req     = 4'b0000;
        tick();
        tick();
        chk("reset", 4'b0000, 2'd0, 1'b0);

        // single requester, 5 cycles then release
        reset_n = 1'b1;
        req     = 4'b0001;
        tick();
        chk("single_first", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("single_hold%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        req = 4'b0000;
        tick();
        chk("single_release", 4'b0000, 2'd0, 1'b0);
        tick();
        chk("single_idle", 4'b0000, 2'd0, 1'b0);

        // all requesting, each owner releases after 3 cycles
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req     = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            o = order[n];
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("rr_n%0d_c%0d", n, c), 4'b0001 << o, o, 1'b1);
                if (c < 2) tick();
            end
            req = 4'b1111 & ~(4'b0001 << o);
            tick();
            req = 4'b1111;
        end
        chk("rr_last_handoff", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        tick();
        chk("rr_idle_sel_held", 4'b0000, 2'd1, 1'b0);

        // owner 2 holds against others
        req = 4'b0100;
        tick();
        chk("hold2_grant", 4'b0100, 2'd2, 1'b1);
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold2_keep%0d", i), 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b1011;
        tick();
        chk("hold2_handoff3", 4'b1000, 2'd3, 1'b1);

        // reset mid-grant
        req = 4'b0010;
        tick();
        chk("pre_reset_gnt1", 4'b0010, 2'd1, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("reset_midgrant", 4'b0000, 2'd0, 1'b0);
        reset_n = 1'b1;
        req     = 4'b1010;
        tick();
        chk("post_reset_first", 4'b0010, 2'd1, 1'b1);

        // simultaneous requests from idle, last owner 1
        req = 4'b0000;
        tick();
        chk("idle_again", 4'b0000, 2'd1, 1'b0);
        req = 4'b0101;
        tick();
        chk("simul_0101", 4'b0100, 2'd2, 1'b1);
        req = 4'b0001;
        tick();
        chk("simul_handoff0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk("simul_idle", 4'b0000, 2'd0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
        // timeout preemption with HOLD_MAX=4
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req     = 4'b0001;
        tick();
        chk("to_grant0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        tick();
        chk("to_preempt", 4'b0000, 2'd0, 1'b0);
        tick();
        chk("to_grant1", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        tick();
        chk("to_idle", 4'b0000, 2'd1, 1'b0);

        // preemption with nobody left: former owner regains
        req = 4'b0001;
        tick();
        chk("to2_grant0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0011;
        tick();
        tick();
        tick();
        tick();
        chk("to2_preempt", 4'b0000, 2'd0, 1'b0);
        req = 4'b0001;
        tick();
        chk("to2_regrant0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();

        // lone requester never preempted
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req     = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("lone%0d", i), 4'b0001, 2'd0, 1'b1);
        end
        req = 4'b0000;
        tick();
        chk("lone_release", 4'b0000, 2'd0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
